// File: rtl/acc_cpu_pkg.sv
// Shared types and field helpers for the parametrised accumulator CPU.
// Opcode and FSM state encodings live here so the core and ALU agree on them.
package acc_cpu_pkg;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC_RD = 3'd2,
    S_EXEC_WR = 3'd3,
    S_HALTED  = 3'd4
  } state_e;

  localparam int OPC_W = 3;

  // Opcode occupies the top OPC_W bits of the instruction word.
  function automatic int opc_lsb(input int data_w);
    return data_w - OPC_W;
  endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational ALU for the accumulator CPU: ADD (carry dropped), AND, XOR, LDA.
// Any other opcode passes the accumulator through unchanged.
module acc_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = a;
    case (op)
      OP_ADD:  result = a + b;
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      OP_LDA:  result = b;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU with req/ack memory port, resume-from-halt and single-step.
// state     | meaning
// S_FETCH   | read instruction at pc, pc++ on ack
// S_DECODE  | dispatch; HLT/SKZ/JMP retire here
// S_EXEC_RD | read operand, update acc on ack
// S_EXEC_WR | write acc to operand address
// S_HALTED  | idle until resume
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter int              ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              resume,
  input  logic              step_en,
  output logic              halted,
  output logic              retire,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc
);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [DATA_W-1:0] ir, ir_nxt;
  logic [DATA_W-1:0] acc_nxt;
  logic [DATA_W-1:0] alu_result;
  logic [ADDR_W-1:0] opnd_addr;
  opcode_e           op;
  logic              zero;
  state_e            after_retire;

  assign op        = opcode_e'(ir[opc_lsb(DATA_W) +: OPC_W]);
  assign opnd_addr = ir[ADDR_W-1:0];
  assign zero      = (acc == '0);

  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (acc),
    .b      (mem_rdata),
    .result (alu_result)
  );

  // Gating with rst drops an in-flight request the moment reset asserts.
  assign mem_req   = rst && (state == S_FETCH || state == S_EXEC_RD || state == S_EXEC_WR);
  assign mem_we    = mem_req && (state == S_EXEC_WR);
  assign mem_addr  = (state == S_FETCH) ? pc : opnd_addr;
  assign mem_wdata = acc;
  assign halted    = (state == S_HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      acc   <= acc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    ir_nxt       = ir;
    acc_nxt      = acc;
    retire       = 1'b0;
    after_retire = step_en ? S_HALTED : S_FETCH;
    case (state)
      S_FETCH: begin
        if (mem_ack) begin
          ir_nxt    = mem_rdata;
          pc_nxt    = pc + 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_HLT: begin
            retire    = 1'b1;
            state_nxt = S_HALTED;
          end
          OP_SKZ: begin
            retire    = 1'b1;
            if (zero) pc_nxt = pc + 1'b1;
            state_nxt = after_retire;
          end
          OP_JMP: begin
            retire    = 1'b1;
            pc_nxt    = opnd_addr;
            state_nxt = after_retire;
          end
          OP_STO:  state_nxt = S_EXEC_WR;
          default: state_nxt = S_EXEC_RD;
        endcase
      end
      S_EXEC_RD: begin
        if (mem_ack) begin
          acc_nxt   = alu_result;
          retire    = 1'b1;
          state_nxt = after_retire;
        end
      end
      S_EXEC_WR: begin
        if (mem_ack) begin
          retire    = 1'b1;
          state_nxt = after_retire;
        end
      end
      S_HALTED: begin
        if (resume) state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboard bench for acc_cpu_core: an ISA-level interpreter predicts bus traffic and
// post-instruction state; a monitor compares them while a responder inserts wait states.
module tb_acc_cpu_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mem_req, mem_we, mem_ack = 1'b0;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata = 8'h00;
  logic       resume = 1'b0, step_en = 1'b0;
  logic       halted, retire;
  logic [4:0] pc;
  logic [7:0] acc;

  acc_cpu_core #(.DATA_W(8), .ADDR_W(5), .RESET_PC(5'd0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resume(resume), .step_en(step_en),
    .halted(halted), .retire(retire), .pc(pc), .acc(acc)
  );

  always #5 clk = ~clk;

  typedef struct {bit we; int addr; int wdata;} bus_t;
  typedef struct {int pc; int acc; bit halted;} ret_t;

  bus_t exp_bus[$];
  ret_t exp_ret[$];
  logic [7:0] mem [32];
  int   model_mem [32];

  int checks = 0, passed = 0;
  int w_mode = 0;
  bit freeze = 1'b1, block_wr = 1'b0, sb_en = 1'b1;
  int retired = 0, exp_total = 0, cyc = 0, first_req = -1, first_halt = -1;
  bit chk_ret = 1'b0, prev_pending = 1'b0, prev_we = 1'b0;
  int prev_addr = 0, prev_wdata = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ISA interpreter: plain arithmetic over a copy of memory.
  task automatic build_model(input bit step, input int hlts, input int max_instr,
                             input int wfix, output int n, output int ncyc);
    int m[32];
    int mpc, macc, ir, op, a, h;
    bus_t b;
    ret_t r;
    for (int i = 0; i < 32; i++) m[i] = mem[i];
    mpc = 0; macc = 0; h = 0; n = 0; ncyc = 0;
    while (n < max_instr) begin
      ir = m[mpc];
      b.we = 0; b.addr = mpc; b.wdata = 0; exp_bus.push_back(b);
      mpc = (mpc + 1) % 32;
      op = ir / 32; a = ir % 32;
      r.halted = step;
      ncyc += 2 + wfix;
      case (op)
        0: begin r.halted = 1; h++; end
        1: if (macc == 0) mpc = (mpc + 1) % 32;
        7: mpc = a;
        6: begin
          b.we = 1; b.addr = a; b.wdata = macc; exp_bus.push_back(b);
          m[a] = macc; ncyc += 1 + wfix;
        end
        default: begin
          b.we = 0; b.addr = a; b.wdata = 0; exp_bus.push_back(b);
          ncyc += 1 + wfix;
          case (op)
            2: macc = (macc + m[a]) % 256;
            3: macc = macc & m[a];
            4: macc = macc ^ m[a];
            default: macc = m[a];
          endcase
        end
      endcase
      r.pc = mpc; r.acc = macc; exp_ret.push_back(r);
      n++;
      if (op == 0 && h == hlts) break;
    end
    for (int i = 0; i < 32; i++) model_mem[i] = m[i];
  endtask

  // Memory responder: per-request wait count, stray acks while idle in random mode.
  bit in_req = 0;
  int wcnt = 0, wtarget = 0;
  always @(negedge clk) begin
    if (!rst || !mem_req) begin
      in_req = 0;
      mem_ack = (rst && w_mode < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    end else if (freeze || (block_wr && mem_we)) begin
      mem_ack = 1'b0;
    end else begin
      if (!in_req) begin
        in_req = 1; wcnt = 0;
        wtarget = (w_mode < 0) ? int'($urandom_range(0, 3)) : w_mode;
      end
      if (wcnt == wtarget) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
        in_req = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  // Monitor: bus transactions, request stability, post-retire architectural state.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (rst && sb_en) begin
      if (mem_req && first_req < 0) first_req = cyc;
      if (halted && first_halt < 0) first_halt = cyc;
      if (prev_pending) begin
        chk("req_held", int'(mem_req), 1);
        chk("addr_stable", int'(mem_addr), prev_addr);
        chk("we_stable", int'(mem_we), int'(prev_we));
        if (prev_we) chk("wdata_stable", int'(mem_wdata), prev_wdata);
      end
      if (chk_ret) begin
        chk_ret = 0;
        if (exp_ret.size() == 0) chk("ret_queue_nonempty", 0, 1);
        else begin
          ret_t r;
          r = exp_ret.pop_front();
          chk("pc_after_retire", int'(pc), r.pc);
          chk("acc_after_retire", int'(acc), r.acc);
          chk("halted_after_retire", int'(halted), int'(r.halted));
        end
      end
      if (mem_req && mem_ack) begin
        if (exp_bus.size() == 0) chk("bus_queue_nonempty", 0, 1);
        else begin
          bus_t b;
          b = exp_bus.pop_front();
          chk("bus_we", int'(mem_we), int'(b.we));
          chk("bus_addr", int'(mem_addr), b.addr);
          if (b.we) chk("bus_wdata", int'(mem_wdata), b.wdata);
        end
      end
      if (retire) begin
        retired++;
        chk_ret = 1;
      end
      prev_pending = mem_req && !mem_ack;
      prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
    end else begin
      prev_pending = 0;
      chk_ret = 0;
    end
  end

  task automatic run(input int wmode, input bit step, input int hlts, input int max_instr,
                     input bit chk_cyc);
    int n, ecyc, budget, bad;
    rst = 0; freeze = 1; resume = 0; step_en = step; w_mode = wmode; sb_en = 1;
    exp_bus.delete(); exp_ret.delete();
    build_model(step, hlts, max_instr, (wmode < 0) ? 0 : wmode, n, ecyc);
    exp_total = n; retired = 0; first_req = -1; first_halt = -1;
    repeat (2) @(negedge clk);
    #2; rst = 1; freeze = 0;
    budget = 0;
    while (budget < 4000) begin
      @(negedge clk); #2;
      budget++;
      if (retired >= exp_total) break;
      if (halted) resume = 1;
      else resume = (wmode < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    resume = 0; freeze = 1;
    if (budget >= 4000) chk("run_timeout", retired, exp_total);
    repeat (2) @(negedge clk);
    #2;
    chk("ret_queue_drained", exp_ret.size(), 0);
    chk("bus_queue_drained", exp_bus.size(), 0);
    bad = 0;
    for (int i = 0; i < 32; i++) if (int'(mem[i]) != model_mem[i]) bad++;
    chk("mem_contents_bad_words", bad, 0);
    if (chk_cyc) chk("cycles_req_to_halt", first_halt - first_req, ecyc);
    rst = 0;
  endtask

  task automatic load_prog1();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'hB0; mem[1] = 8'h51; mem[2] = 8'hD2; mem[3] = 8'h00;
    mem[16] = 8'h05; mem[17] = 8'hFE;
  endtask

  initial begin
    int budget;
    #3;
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_retire", int'(retire), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_acc", int'(acc), 0);

    load_prog1();
    run(0, 0, 1, 20, 1);
    chk("prog1_store_value", int'(mem[18]), 3);
    chk("prog1_retires", retired, 4);

    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'h20; mem[1] = 8'h00; mem[2] = 8'hFF; mem[31] = 8'h00;
    run(0, 0, 1, 20, 1);
    chk("skz_jmp_retires", retired, 3);

    load_prog1();
    run(3, 0, 1, 20, 1);
    chk("wait_store_value", int'(mem[18]), 3);

    load_prog1();
    run(0, 1, 1, 20, 0);
    chk("step_retires", retired, 4);

    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[1] = 8'hB0; mem[16] = 8'h05;
    run(0, 0, 2, 20, 0);
    chk("resume_retires", retired, 3);

    // Reset while a write is pending and never acknowledged.
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'hD2; mem[18] = 8'h77;
    sb_en = 0; block_wr = 1; w_mode = 0; step_en = 0; freeze = 0; rst = 0;
    repeat (2) @(negedge clk);
    #2; rst = 1;
    budget = 0;
    while (!(mem_req && mem_we) && budget < 20) begin
      @(negedge clk); #2; budget++;
    end
    chk("reach_exec_wr", int'(mem_req && mem_we), 1);
    rst = 0;
    #1;
    chk("abort_mem_req", int'(mem_req), 0);
    chk("abort_mem_we", int'(mem_we), 0);
    @(negedge clk); #2;
    chk("abort_no_write", int'(mem[18]), 8'h77);
    rst = 1;
    #1;
    chk("post_rst_req", int'(mem_req), 1);
    chk("post_rst_addr", int'(mem_addr), 0);
    chk("post_rst_acc", int'(acc), 0);
    rst = 0; block_wr = 0; sb_en = 1;

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
      run(-1, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), 30, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
